instr_fetch_unit: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Accepts PC addresses with a valid/ready handshake and issues word reads to instruction memory, which has a fixed 1-cycle read latency.
- Buffers the returned instructions with their PCs in a small in-order queue and presents them to decode with a valid/ready handshake.
- A taken branch or jump raises `flush`, which discards every queued and in-flight fetch.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_queue.sv | 77 +++++++
 rtl/instr_fetch_unit_chk.sv | 30 +++
 rtl/instr_fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   XLEN          : address / instruction width
//   RESET_PC      : PC reported on the decode interface while empty after reset
//   fetch_entry_t : one queued instruction {data, pc, misalign}
//   is_misaligned : true when the low two PC bits are not zero
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fetch_entry_t;

  function automatic logic is_misaligned(input logic [1:0] pc_lo);
    return (pc_lo != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// In-order circular buffer of fetch_entry_t.
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_clear         : drop every stored entry (redirect)
//   i_push/i_push_entry : write one entry at the tail (ignored when full)
//   i_pop           : retire the head entry (ignored when empty)
//   o_head          : entry at the head
//   o_full/o_empty  : status flags
//   o_count         : number of stored entries
// ---------------------------------------------------------------------------
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  fetch_entry_t     i_push_entry,
  input  logic             i_pop,
  output fetch_entry_t     o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == {CNT_W{1'b0}});
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointer and count bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {CNT_W{1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head never shows stale power-up data.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '{data: {XLEN{1'b0}}, pc: {XLEN{1'b0}}, misalign: 1'b0};
      end
    end else if (w_push && !i_clear) begin
      r_mem[r_wr_ptr] <= i_push_entry;
    end
  end

endmodule

// File: rtl/instr_fetch_unit_chk.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit_chk
// Protocol invariants of the fetch stage.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_push, i_full : queue write and full flag
//   i_pop, i_empty : queue read and empty flag
//   i_imem_en      : memory read strobe
//   i_pc_ready     : PC handshake ready
// ---------------------------------------------------------------------------
module instr_fetch_unit_chk (
  input logic i_clk,
  input logic i_reset,
  input logic i_push,
  input logic i_full,
  input logic i_pop,
  input logic i_empty,
  input logic i_imem_en,
  input logic i_pc_ready
);

  a_no_push_when_full: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_push && i_full));

  a_no_pop_when_empty: assert property (@(posedge i_clk) disable iff (i_reset)
    !(i_pop && i_empty));

  a_en_implies_ready: assert property (@(posedge i_clk) disable iff (i_reset)
    i_imem_en |-> i_pc_ready);

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage between the PC and decode. Accepted PCs are issued to an
// instruction memory with 1-cycle read latency; responses are queued with
// their PC and presented to decode in order.
//   i_clk, i_reset        : clock, synchronous active-high reset
//   i_pc_addr/i_pc_valid/o_pc_ready : PC handshake
//   i_flush               : redirect, drops queued and in-flight fetches
//   o_imem_en/o_imem_addr : memory read strobe and word-aligned address
//   i_imem_rdata          : read data, one cycle after o_imem_en
//   o_inst_valid/i_inst_ready : decode handshake
//   o_inst_data/o_inst_pc/o_inst_misalign : head entry
//   o_occupancy           : queued entries plus in-flight request
// XLEN must match fetch_pkg::XLEN because the queue entry type uses it.
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DEPTH    = 2,
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC,
  localparam int             CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [XLEN-1:0]  i_pc_addr,
  input  logic             i_pc_valid,
  output logic             o_pc_ready,
  input  logic             i_flush,
  output logic             o_imem_en,
  output logic [XLEN-1:0]  o_imem_addr,
  input  logic [XLEN-1:0]  i_imem_rdata,
  output logic             o_inst_valid,
  input  logic             i_inst_ready,
  output logic [XLEN-1:0]  o_inst_data,
  output logic [XLEN-1:0]  o_inst_pc,
  output logic             o_inst_misalign,
  output logic [CNT_W-1:0] o_occupancy
);

  logic             r_credit_ok;
  logic             r_inflight;
  logic [XLEN-1:0]  r_inflight_pc;
  logic             r_inflight_misalign;
  fetch_entry_t     r_hold;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_next_count;
  logic [CNT_W-1:0] w_next_occ;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;
  fetch_entry_t     w_out;

  // Credit is registered, so a pop only frees a slot from the next cycle on.
  assign o_pc_ready   = r_credit_ok && !i_flush && !i_reset;
  assign w_accept     = i_pc_valid && o_pc_ready;
  assign o_imem_en    = w_accept;
  assign o_imem_addr  = {i_pc_addr[XLEN-1:2], 2'b00};

  // The response of a flushed request is dropped here.
  assign w_push       = r_inflight && !i_flush;
  assign w_pop        = o_inst_valid && i_inst_ready;
  assign o_inst_valid = !w_empty;
  assign w_push_entry = '{data: i_imem_rdata, pc: r_inflight_pc, misalign: r_inflight_misalign};

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (i_flush),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_count      (w_count)
  );

  // Next-cycle queue count and occupancy, from which the credit is registered.
  always_comb begin
    w_next_count = w_count;
    if (i_flush) begin
      w_next_count = {CNT_W{1'b0}};
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_next_count = w_count + CNT_W'(1);
        2'b01:   w_next_count = w_count - CNT_W'(1);
        default: w_next_count = w_count;
      endcase
    end
    w_next_occ = w_next_count + CNT_W'(w_accept);
  end

  // Credit register: set while queued plus in-flight entries leave a free slot.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_credit_ok <= 1'b1;
    end else begin
      r_credit_ok <= (w_next_occ < CNT_W'(DEPTH));
    end
  end

  // In-flight slot: PC and misalign flag of the request awaiting its response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_inflight          <= 1'b0;
      r_inflight_pc       <= {XLEN{1'b0}};
      r_inflight_misalign <= 1'b0;
    end else begin
      r_inflight <= w_accept;
      if (w_accept) begin
        r_inflight_pc       <= i_pc_addr;
        r_inflight_misalign <= is_misaligned(i_pc_addr[1:0]);
      end
    end
  end

  // Last shown head, so the decode outputs hold steady while the queue is empty.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_hold <= '{data: {XLEN{1'b0}}, pc: RESET_PC, misalign: 1'b0};
    end else if (!w_empty) begin
      r_hold <= w_head;
    end
  end

  // Decode-side view: live head when available, held value otherwise.
  always_comb begin
    w_out = r_hold;
    if (!w_empty) begin
      w_out = w_head;
    end else begin
      w_out = r_hold;
    end
  end

  assign o_inst_data     = w_out.data;
  assign o_inst_pc       = w_out.pc;
  assign o_inst_misalign = w_out.misalign;
  assign o_occupancy     = w_count + CNT_W'(r_inflight);

  instr_fetch_unit_chk u_chk (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_push     (w_push),
    .i_full     (w_full),
    .i_pop      (w_pop),
    .i_empty    (w_empty),
    .i_imem_en  (o_imem_en),
    .i_pc_ready (o_pc_ready)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench: a per-cycle vector table for streaming/backpressure,
// hand sequences for misalign, flush, random ready and reset, and a
// scoreboard of expected {pc, data, misalign} filled on every accepted PC.
// The memory model returns 0x13 + aligned address one cycle after a read.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam int          XLEN     = 32;
  localparam int          CNT_W    = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic [XLEN-1:0]  pc_addr;
  logic             pc_valid;
  logic             pc_ready;
  logic             flush;
  logic             imem_en;
  logic [XLEN-1:0]  imem_addr;
  logic [XLEN-1:0]  imem_rdata;
  logic             inst_valid;
  logic             inst_ready;
  logic [XLEN-1:0]  inst_data;
  logic [XLEN-1:0]  inst_pc;
  logic             inst_misalign;
  logic [CNT_W-1:0] occupancy;

  instr_fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_pc_addr       (pc_addr),
    .i_pc_valid      (pc_valid),
    .o_pc_ready      (pc_ready),
    .i_flush         (flush),
    .o_imem_en       (imem_en),
    .o_imem_addr     (imem_addr),
    .i_imem_rdata    (imem_rdata),
    .o_inst_valid    (inst_valid),
    .i_inst_ready    (inst_ready),
    .o_inst_data     (inst_data),
    .o_inst_pc       (inst_pc),
    .o_inst_misalign (inst_misalign),
    .o_occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  // Instruction memory: 1-cycle latency, garbage when not read.
  always @(posedge clk) begin
    imem_rdata <= imem_en ? (imem_addr + 32'h0000_0013) : 32'hDEAD_BEEF;
  end

  typedef struct packed {
    logic        pv;
    logic [31:0] pc;
    logic        ir;
    logic        e_rdy;
    logic        e_val;
    logic [1:0]  e_occ;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  vec_t tab [19];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic last_acc;
  int   acc;
  logic [31:0] next_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock: scoreboard bookkeeping at negedge+1, then advance to next negedge.
  task automatic cyc();
    exp_t e;
    #1;
    last_acc = pc_valid && pc_ready;
    chk("imem_en", 32'(imem_en), 32'(last_acc));
    if (reset || flush) chk("ready_blocked", 32'(pc_ready), 32'd0);
    if (last_acc) begin
      chk("imem_addr", imem_addr, {pc_addr[31:2], 2'b00});
      sb.push_back('{pc: pc_addr, data: {pc_addr[31:2], 2'b00} + 32'h0000_0013,
                     mis: (pc_addr[1:0] != 2'b00)});
    end
    if (!reset && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_extra: got pc %h, expected no output", inst_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", inst_pc, e.pc);
        chk("sb_data", inst_data, e.data);
        chk("sb_mis", 32'(inst_misalign), 32'(e.mis));
      end
    end
    if (reset || flush) sb.delete();
    @(negedge clk);
  endtask

  task automatic drain();
    pc_valid   = 1'b0;
    inst_ready = 1'b1;
    flush      = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (sb.size() == 0 && !inst_valid && occupancy == 2'd0) break;
      cyc();
    end
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_occ", 32'(occupancy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    //          pv    pc            ir    rdy   val   occ
    tab[0]  = '{1'b1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 2'd0};
    tab[1]  = '{1'b1, 32'h0000_0004, 1'b1, 1'b1, 1'b0, 2'd1};
    tab[2]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b0, 1'b1, 2'd2};
    tab[3]  = '{1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b1, 2'd1};
    tab[4]  = '{1'b1, 32'h0000_000C, 1'b1, 1'b1, 1'b0, 2'd1};
    tab[5]  = '{1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b1, 2'd2};
    tab[6]  = '{1'b0, 32'h0000_0010, 1'b1, 1'b1, 1'b1, 2'd1};
    tab[7]  = '{1'b0, 32'h0000_0010, 1'b1, 1'b1, 1'b0, 2'd0};
    tab[8]  = '{1'b1, 32'h0000_0020, 1'b0, 1'b1, 1'b0, 2'd0};
    tab[9]  = '{1'b1, 32'h0000_0024, 1'b0, 1'b1, 1'b0, 2'd1};
    tab[10] = '{1'b1, 32'h0000_0028, 1'b0, 1'b0, 1'b1, 2'd2};
    tab[11] = '{1'b1, 32'h0000_0028, 1'b0, 1'b0, 1'b1, 2'd2};
    tab[12] = '{1'b1, 32'h0000_0028, 1'b0, 1'b0, 1'b1, 2'd2};
    tab[13] = '{1'b1, 32'h0000_0028, 1'b0, 1'b0, 1'b1, 2'd2};
    tab[14] = '{1'b1, 32'h0000_0028, 1'b1, 1'b0, 1'b1, 2'd2};
    tab[15] = '{1'b1, 32'h0000_0028, 1'b1, 1'b1, 1'b1, 2'd1};
    tab[16] = '{1'b0, 32'h0000_002C, 1'b1, 1'b1, 1'b0, 2'd1};
    tab[17] = '{1'b0, 32'h0000_002C, 1'b1, 1'b1, 1'b1, 2'd1};
    tab[18] = '{1'b0, 32'h0000_002C, 1'b1, 1'b1, 1'b0, 2'd0};

    reset      = 1'b1;
    pc_valid   = 1'b0;
    pc_addr    = 32'h0;
    flush      = 1'b0;
    inst_ready = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_mis", 32'(inst_misalign), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, RESET_PC);
    chk("rst_ready", 32'(pc_ready), 32'd0);
    cyc();
    reset = 1'b0;

    // Streaming then backpressure, cycle by cycle
    for (int i = 0; i < 19; i++) begin
      pc_valid   = tab[i].pv;
      pc_addr    = tab[i].pc;
      inst_ready = tab[i].ir;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(pc_ready), 32'(tab[i].e_rdy));
      chk($sformatf("v%0d_valid", i), 32'(inst_valid), 32'(tab[i].e_val));
      chk($sformatf("v%0d_occ", i), 32'(occupancy), 32'(tab[i].e_occ));
      cyc();
    end
    drain();

    // Misaligned PC
    pc_valid = 1'b1; pc_addr = 32'h0000_0006; inst_ready = 1'b1;
    #1;
    chk("mis_imem_en", 32'(imem_en), 32'd1);
    chk("mis_imem_addr", imem_addr, 32'h0000_0004);
    cyc();
    pc_valid = 1'b0;
    cyc();
    #1;
    chk("mis_valid", 32'(inst_valid), 32'd1);
    chk("mis_pc", inst_pc, 32'h0000_0006);
    chk("mis_flag", 32'(inst_misalign), 32'd1);
    chk("mis_data", inst_data, 32'h0000_0017);
    cyc();
    drain();

    // Flush with one queued and one in flight
    pc_valid = 1'b1; pc_addr = 32'h0000_0040; inst_ready = 1'b0;
    cyc();
    pc_addr = 32'h0000_0044;
    cyc();
    pc_addr = 32'h0000_0048; flush = 1'b1;
    #1;
    chk("fl_occ", 32'(occupancy), 32'd2);
    chk("fl_valid", 32'(inst_valid), 32'd1);
    chk("fl_imem_en", 32'(imem_en), 32'd0);
    cyc();
    flush = 1'b0; pc_addr = 32'h0000_0100; inst_ready = 1'b1;
    #1;
    chk("fl_after_valid", 32'(inst_valid), 32'd0);
    chk("fl_after_occ", 32'(occupancy), 32'd0);
    chk("fl_after_ready", 32'(pc_ready), 32'd1);
    cyc();
    pc_valid = 1'b0;
    cyc();
    #1;
    chk("fl_next_pc", inst_pc, 32'h0000_0100);
    cyc();
    drain();

    // Random decode readiness, 20 transactions across pointer wrap
    acc = 0;
    next_pc = 32'h0000_0200;
    for (int c = 0; c < 400 && !(acc == 20 && sb.size() == 0); c++) begin
      pc_valid   = (acc < 20) ? ($urandom_range(0, 3) != 0) : 1'b0;
      pc_addr    = next_pc;
      inst_ready = 1'($urandom_range(0, 1));
      #1;
      chk("occ_max", 32'(occupancy <= 2'd2), 32'd1);
      cyc();
      if (last_acc) begin
        acc++;
        next_pc = next_pc + 32'd4;
      end
    end
    chk("rand_acc", 32'(acc), 32'd20);
    chk("rand_sb", 32'(sb.size()), 32'd0);
    drain();

    // Reset with two entries queued
    pc_valid = 1'b1; pc_addr = 32'h0000_0300; inst_ready = 1'b0;
    cyc();
    pc_addr = 32'h0000_0304;
    cyc();
    pc_valid = 1'b0;
    cyc();
    #1;
    chk("rm_occ_before", 32'(occupancy), 32'd2);
    reset = 1'b1;
    #1;
    chk("rm_ready_in_reset", 32'(pc_ready), 32'd0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rm_valid", 32'(inst_valid), 32'd0);
    chk("rm_occ", 32'(occupancy), 32'd0);
    chk("rm_pc", inst_pc, RESET_PC);
    chk("rm_data", inst_data, 32'd0);
    chk("rm_ready", 32'(pc_ready), 32'd1);
    cyc();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
